// File: rtl/prbs_pkg.sv
// Shared definitions for the e-link PRBS checker: polynomial taps, lane FSM
// states and fixed counter widths.
package prbs_pkg;

    localparam int DEF_CNT_W    = 32;
    localparam int UNLOCK_CNT_W = 16;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } lane_state_e;

    // b[n] = b[n-A] xor b[n-B]; A is always the sequence order
    function automatic int prbs_tap_a(input int order);
        case (order)
            7:       return 7;
            15:      return 15;
            23:      return 23;
            31:      return 31;
            default: return order;
        endcase
    endfunction

    function automatic int prbs_tap_b(input int order);
        case (order)
            7:       return 6;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return order - 1;
        endcase
    endfunction

endpackage

// File: rtl/prbs_lane_check.sv
// Single-link self-synchronising PRBS checker: history, predictor, lock FSM,
// run counters and saturating error/good counters.
module prbs_lane_check
    import prbs_pkg::*;
#(
    parameter int LINK_W     = 8,
    parameter int PRBS_ORDER = 7,
    parameter int LOCK_GOOD  = 64,
    parameter int UNLOCK_BAD = 4,
    parameter int CNT_W      = DEF_CNT_W,
    parameter bit ENABLE     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [LINK_W-1:0]       data,
    input  logic                    data_valid,
    input  logic                    cnt_clear,
    output logic                    locked,
    output logic                    err,
    output logic [CNT_W-1:0]        good_cnt,
    output logic [CNT_W-1:0]        err_word_cnt,
    output logic [CNT_W-1:0]        err_bit_cnt,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int TAP_A      = prbs_tap_a(PRBS_ORDER);
    localparam int TAP_B      = prbs_tap_b(PRBS_ORDER);
    localparam int WIN_W      = PRBS_ORDER + LINK_W;
    localparam int FILL_WORDS = (PRBS_ORDER + LINK_W - 1) / LINK_W;
    localparam int FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int GR_W       = $clog2(LOCK_GOOD + 1);
    localparam int BR_W       = $clog2(UNLOCK_BAD + 1);
    localparam int POP_W      = $clog2(LINK_W + 1);

    localparam logic [FILL_W-1:0] FILL_LAST_C = FILL_W'(FILL_WORDS);
    localparam logic [GR_W-1:0]   LOCK_LAST   = GR_W'(LOCK_GOOD - 1);
    localparam logic [BR_W-1:0]   UNLOCK_LAST = BR_W'(UNLOCK_BAD - 1);

    lane_state_e             state;
    logic [PRBS_ORDER-1:0]   hist;
    logic [FILL_W-1:0]       fill_cnt;
    logic [GR_W-1:0]         good_run;
    logic [BR_W-1:0]         bad_run;

    logic [WIN_W-1:0]        win;
    logic [LINK_W-1:0]       pred;
    logic [LINK_W-1:0]       diff;
    logic [POP_W-1:0]        mis_bits;
    logic                    zero_run;
    logic                    word_ok;
    logic                    evt;
    logic                    filling;
    logic                    good_word;
    logic                    bad_word;
    logic                    unlock_ev;
    logic [CNT_W:0]          bit_sum;

    // Higher index = older bit; hist[0] is the most recent received bit.
    assign win = {hist, data};

    always_comb begin
        pred     = '0;
        mis_bits = '0;
        for (int p = 0; p < LINK_W; p++) begin
            pred[p] = win[p + TAP_A] ^ win[p + TAP_B];
        end
        diff = data ^ pred;
        for (int p = 0; p < LINK_W; p++) begin
            mis_bits = mis_bits + POP_W'(diff[p]);
        end
    end

    // ORDER consecutive zeros never occur in a real PRBS but satisfy the
    // recursion, so a stuck-at-zero link must still be seen as mismatching.
    assign zero_run  = (win[PRBS_ORDER-1:0] == '0);
    assign word_ok   = (diff == '0) && !zero_run;
    assign evt       = ENABLE && data_valid;
    assign filling   = (fill_cnt < FILL_LAST_C);
    assign good_word = evt && !filling && (state == ST_LOCKED) && word_ok;
    assign bad_word  = evt && !filling && (state == ST_LOCKED) && !word_ok;
    assign unlock_ev = bad_word && (bad_run == UNLOCK_LAST);
    assign bit_sum   = {1'b0, err_bit_cnt} + (CNT_W+1)'(mis_bits);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_SEARCH;
            locked   <= 1'b0;
            err      <= 1'b0;
            hist     <= '0;
            fill_cnt <= '0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            err <= 1'b0;
            if (evt) begin
                hist <= win[PRBS_ORDER-1:0];
                if (filling) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end else if (state == ST_SEARCH) begin
                    if (!word_ok) begin
                        good_run <= '0;
                    end else if (good_run == LOCK_LAST) begin
                        good_run <= good_run + 1'b1;
                        bad_run  <= '0;
                        state    <= ST_LOCKED;
                        locked   <= 1'b1;
                    end else begin
                        good_run <= good_run + 1'b1;
                    end
                end else begin
                    if (word_ok) begin
                        bad_run <= '0;
                    end else begin
                        err <= 1'b1;
                        if (bad_run == UNLOCK_LAST) begin
                            bad_run  <= '0;
                            good_run <= '0;
                            fill_cnt <= '0;
                            state    <= ST_SEARCH;
                            locked   <= 1'b0;
                        end else begin
                            bad_run <= bad_run + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Clear wins over any increment but leaves the FSM and runs alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt     <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
            unlock_cnt   <= '0;
        end else if (cnt_clear) begin
            good_cnt     <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
            unlock_cnt   <= '0;
        end else begin
            if (good_word && !(&good_cnt)) begin
                good_cnt <= good_cnt + 1'b1;
            end
            if (bad_word) begin
                if (!(&err_word_cnt)) begin
                    err_word_cnt <= err_word_cnt + 1'b1;
                end
                err_bit_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            end
            if (unlock_ev && !(&unlock_cnt)) begin
                unlock_cnt <= unlock_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prbs_elink_checker.sv
// Parallel PRBS checker for NLINKS e-links with a registered per-link counter
// readout selected by link_sel.
module prbs_elink_checker
    import prbs_pkg::*;
#(
    parameter int               NLINKS     = 14,
    parameter int               LINK_W     = 8,
    parameter int               PRBS_ORDER = 7,
    parameter int               LOCK_GOOD  = 64,
    parameter int               UNLOCK_BAD = 4,
    parameter int               CNT_W      = DEF_CNT_W,
    parameter logic [NLINKS-1:0] LINK_MASK = '1
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    input  logic [NLINKS*LINK_W-1:0]                    data_i,
    input  logic                                        data_valid,
    input  logic                                        cnt_clear,
    input  logic [(NLINKS > 1 ? $clog2(NLINKS) : 1)-1:0] link_sel,
    output logic [NLINKS-1:0]                           locked_o,
    output logic [NLINKS-1:0]                           err_o,
    output logic [CNT_W-1:0]                            good_cnt_o,
    output logic [CNT_W-1:0]                            err_word_cnt_o,
    output logic [CNT_W-1:0]                            err_bit_cnt_o,
    output logic [UNLOCK_CNT_W-1:0]                     unlock_cnt_o
);

    localparam int SEL_W = (NLINKS > 1) ? $clog2(NLINKS) : 1;

    logic [1:0]                               rst_sync;
    logic                                     rst_n_s;
    logic [NLINKS-1:0][CNT_W-1:0]             good_cnt_l;
    logic [NLINKS-1:0][CNT_W-1:0]             err_word_cnt_l;
    logic [NLINKS-1:0][CNT_W-1:0]             err_bit_cnt_l;
    logic [NLINKS-1:0][UNLOCK_CNT_W-1:0]      unlock_cnt_l;
    logic                                     sel_ok;

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_s = rst_sync[1];

    for (genvar g = 0; g < NLINKS; g++) begin : g_lane
        prbs_lane_check #(
            .LINK_W     (LINK_W),
            .PRBS_ORDER (PRBS_ORDER),
            .LOCK_GOOD  (LOCK_GOOD),
            .UNLOCK_BAD (UNLOCK_BAD),
            .CNT_W      (CNT_W),
            .ENABLE     (LINK_MASK[g])
        ) u_lane (
            .clock        (clock),
            .reset_n      (rst_n_s),
            .data         (data_i[g*LINK_W +: LINK_W]),
            .data_valid   (data_valid),
            .cnt_clear    (cnt_clear),
            .locked       (locked_o[g]),
            .err          (err_o[g]),
            .good_cnt     (good_cnt_l[g]),
            .err_word_cnt (err_word_cnt_l[g]),
            .err_bit_cnt  (err_bit_cnt_l[g]),
            .unlock_cnt   (unlock_cnt_l[g])
        );
    end

    assign sel_ok = ({1'b0, link_sel} < (SEL_W+1)'(NLINKS));

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            good_cnt_o     <= '0;
            err_word_cnt_o <= '0;
            err_bit_cnt_o  <= '0;
            unlock_cnt_o   <= '0;
        end else if (sel_ok) begin
            good_cnt_o     <= good_cnt_l[link_sel];
            err_word_cnt_o <= err_word_cnt_l[link_sel];
            err_bit_cnt_o  <= err_bit_cnt_l[link_sel];
            unlock_cnt_o   <= unlock_cnt_l[link_sel];
        end else begin
            good_cnt_o     <= '0;
            err_word_cnt_o <= '0;
            err_bit_cnt_o  <= '0;
            unlock_cnt_o   <= '0;
        end
    end

endmodule

// File: doc/prbs_elink_checker.md
PRBS_ELINK_CHECKER -- requirements
Module: prbs_elink_checker

Interface
REQ-001 Parameter NLINKS, default 14: number of e-link channels checked in parallel.
REQ-002 Parameter LINK_W, default 8: bits per link per clock; legal range 4..16.
REQ-003 Parameter PRBS_ORDER, default 7: sequence order; legal values 7 (x^7+x^6+1), 15 (x^15+x^14+1), 23 (x^23+x^18+1), 31 (x^31+x^28+1).
REQ-004 Parameter LOCK_GOOD, default 64: consecutive matching words needed to lock.
REQ-005 Parameter UNLOCK_BAD, default 4: consecutive mismatching words that drop lock.
REQ-006 Parameter CNT_W, default 32: width of every counter.
REQ-007 Parameter LINK_MASK, default all ones, NLINKS bits: a 0 disables that link.
REQ-008 clock  in  1  40 MHz frame clock; all logic is on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 data_i  in  NLINKS*LINK_W  received frames; link k occupies [k*LINK_W +: LINK_W]; MSB is the earliest bit in time.
REQ-011 data_valid  in  1  qualifies data_i for the current cycle.
REQ-012 cnt_clear  in  1  synchronous clear of all counters.
REQ-013 link_sel  in  ceil(log2(NLINKS))  selects the link for counter readout.
REQ-014 locked_o  out  NLINKS  per-link LOCKED state.
REQ-015 err_o  out  NLINKS  per-link one-cycle mismatch pulse, asserted only while LOCKED.
REQ-016 good_cnt_o, err_word_cnt_o, err_bit_cnt_o  out  CNT_W each  counters of the selected link.
REQ-017 unlock_cnt_o  out  16  number of LOCKED-to-SEARCH transitions on the selected link.

Function
REQ-018 Each link is self-synchronising: a history register of the last PRBS_ORDER received bits predicts the next LINK_W bits using b[n] = b[n-A] xor b[n-B].
REQ-019 On every valid word the history register is updated with the received bits, whether they match or not.
REQ-020 A word matches when every bit of the received word equals its predicted bit; mismatch_bits is the popcount of the XOR.
REQ-021 The per-link FSM has states SEARCH, LOCKED.
REQ-022 In SEARCH, a match increments good_run and a mismatch zeroes it; when good_run reaches LOCK_GOOD the link goes to LOCKED and bad_run is zeroed.
REQ-023 The first ceil(PRBS_ORDER/LINK_W) valid words after reset or unlock are history fill; they never count as matches.
REQ-024 In LOCKED, a mismatch increments bad_run and a match zeroes it; when bad_run reaches UNLOCK_BAD the link goes to SEARCH, good_run is zeroed, and unlock_cnt increments.
REQ-025 Counting happens only while LOCKED: good_cnt increments per matching word, err_word_cnt per mismatching word, and err_bit_cnt by mismatch_bits.
REQ-026 All counters saturate at all-ones; unlock_cnt saturates at 16'hFFFF.
REQ-027 cnt_clear zeroes every counter and takes priority over any increment in the same cycle; it does not affect FSM state, good_run or bad_run.
REQ-028 With data_valid low, no state, history, run or counter changes, and err_o is 0.
REQ-029 Latency: locked_o and err_o are registered and reflect the word presented one clock earlier.
REQ-030 The readout outputs are registered and reflect link_sel and the counter values of the previous clock.
REQ-031 A single injected bit error produces up to 3 word-level mismatches (the bit itself plus its two tap positions); this is required behaviour.
REQ-032 Masked links hold SEARCH, and their locked_o, err_o and counters stay 0.

Reset
REQ-033 reset_n low asynchronously puts every link in SEARCH and zeroes history, good_run, bad_run, the fill counter, all counters and all outputs.
REQ-034 Reset deassertion is synchronised internally, with a two-flop release, before it reaches the FSMs.
REQ-035 Reset asserted mid-lock takes effect immediately, with no pulse on err_o.

Structure
REQ-036 Polynomial tap table (order to A, B), the FSM state enum and the counter-width constants shall live in a shared package, prbs_pkg.
REQ-037 One sub-module, prbs_lane_check, holds the history register, predictor, FSM, runs and counters for a single link; the top generates NLINKS instances plus the readout mux.

Verification
REQ-038 Clean PRBS-7 stream on all 14 links, 100 valid words -> locked_o = 14'h3FFF at word 64 + fill + 1, good_cnt = 100 - 64 - fill, err counts 0.
REQ-039 Locked link 3, flip one bit in one word -> err_o[3] pulses 1 to 3 times, err_bit_cnt(3) = 3, other links unaffected, lock held.
REQ-040 Locked link 0, 4 consecutive all-zero corrupted words -> locked_o[0] falls after the 4th word, unlock_cnt(0) = 1, relock after 64 + fill clean words.
REQ-041 cnt_clear in the same cycle as an error on a locked link -> counters read 0 next cycle, locked_o unchanged.
REQ-042 Force err_word_cnt near 2^CNT_W - 1 via a small CNT_W = 4 build, then 20 errors -> counter holds 4'hF.
REQ-043 Assert reset_n low mid-lock between clock edges -> locked_o = 0 without waiting for an edge, all readouts 0 after release.
